// File: rtl/tcb_pkg.sv
// Shared types and helpers for the TCB classifier back-end.
// Holds the controller state encoding, default score/index widths and the ceil-divide helper.
package tcb_pkg;

  localparam int SCORE_W_DEF = 40;
  localparam int IDX_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/tcb_argmax_margin_if.sv
// Frame-in / result-out bundle of the argmax-margin classifier back-end.
// Both sides are valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// valid is held with stable payload until it is taken, and ready may be given without waiting for valid.
interface tcb_argmax_margin_if #(
  parameter int N_CLASS = 10,
  parameter int SCORE_W = 40,
  parameter int IDX_W   = 32
);
  logic [N_CLASS*SCORE_W-1:0] layer_out;
  logic                       in_valid;
  logic                       in_ready;
  logic [IDX_W-1:0]           predict;
  logic [SCORE_W-1:0]         max_score;
  logic [SCORE_W:0]           margin;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output layer_out, in_valid, out_ready,
    input  in_ready, predict, max_score, margin, out_valid
  );

  modport slave (
    input  layer_out, in_valid, out_ready,
    output in_ready, predict, max_score, margin, out_valid
  );
endinterface

// File: rtl/tcb_top2_update.sv
// One combinational lane of the top-2 tracker: folds a single class score into (best, second, idx).
// Strict signed greater-than keeps the lowest index on a tie and pushes the tied score into second.
module tcb_top2_update #(
  parameter int SCORE_W = 40,
  parameter int IDX_W   = 32
) (
  input  logic signed [SCORE_W-1:0] score,
  input  logic        [IDX_W-1:0]   cls,
  input  logic                      en,
  input  logic signed [SCORE_W-1:0] best,
  input  logic signed [SCORE_W-1:0] second,
  input  logic        [IDX_W-1:0]   idx,
  output logic signed [SCORE_W-1:0] best_nxt,
  output logic signed [SCORE_W-1:0] second_nxt,
  output logic        [IDX_W-1:0]   idx_nxt
);

  always_comb begin
    best_nxt   = best;
    second_nxt = second;
    idx_nxt    = idx;
    if (en) begin
      if (score > best) begin
        second_nxt = best;
        best_nxt   = score;
        idx_nxt    = cls;
      end else if (score > second) begin
        second_nxt = score;
      end
    end
  end

endmodule

// File: rtl/tcb_argmax_margin.sv
// Classifier back-end: captures a frame of signed scores, scans LANES classes per cycle and
// returns winning index, winning score and best-minus-second margin, held until the consumer takes it.
module tcb_argmax_margin
  import tcb_pkg::*;
#(
  parameter int N_CLASS = 10,
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int LANES   = 2,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  tcb_argmax_margin_if.slave   bus,
  output state_t               state_dbg
);

  localparam int S       = ceil_div(N_CLASS, LANES);
  localparam int G_W     = $clog2(S) + 1;
  localparam int FRAME_W = S * LANES * SCORE_W;
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  state_t state, state_nxt;
  logic   in_ready, out_valid, accept, last_group;

  // Frame is zero-padded up to a whole number of groups; padded lanes are disabled, never compared.
  logic        [FRAME_W-1:0]  frame;
  logic signed [SCORE_W-1:0]  best, second;
  logic        [IDX_W-1:0]    idx;
  logic        [G_W-1:0]      g;

  logic        [IDX_W-1:0]    predict_r;
  logic        [SCORE_W-1:0]  max_score_r;
  logic        [SCORE_W:0]    margin_r, margin_nxt;

  logic signed [SCORE_W-1:0]  lane_score [LANES];
  logic        [IDX_W-1:0]    lane_cls   [LANES];
  logic                       lane_en    [LANES];
  logic signed [SCORE_W-1:0]  best_c     [LANES+1];
  logic signed [SCORE_W-1:0]  second_c   [LANES+1];
  logic        [IDX_W-1:0]    idx_c      [LANES+1];

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_group = (g == G_W'(S - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = SCAN;
      end
      SCAN: begin
        if (last_group) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Route the current group's scores onto the lanes; class index follows group*LANES+lane.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_score[l] = '0;
      lane_cls[l]   = '0;
      lane_en[l]    = 1'b0;
      for (int gg = 0; gg < S; gg++) begin
        if (g == G_W'(gg)) begin
          lane_score[l] = frame[(gg*LANES+l)*SCORE_W +: SCORE_W];
          lane_cls[l]   = IDX_W'(gg*LANES + l);
          lane_en[l]    = (gg*LANES + l) < N_CLASS;
        end
      end
    end
  end

  assign best_c[0]   = best;
  assign second_c[0] = second;
  assign idx_c[0]    = idx;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    tcb_top2_update #(.SCORE_W(SCORE_W), .IDX_W(IDX_W)) u_upd (
      .score      (lane_score[l]),
      .cls        (lane_cls[l]),
      .en         (lane_en[l]),
      .best       (best_c[l]),
      .second     (second_c[l]),
      .idx        (idx_c[l]),
      .best_nxt   (best_c[l+1]),
      .second_nxt (second_c[l+1]),
      .idx_nxt    (idx_c[l+1])
    );
  end

  // best >= second always holds, so the sign-extended difference is never negative.
  assign margin_nxt = {best_c[LANES][SCORE_W-1], best_c[LANES]}
                    - {second_c[LANES][SCORE_W-1], second_c[LANES]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame       <= '0;
      best        <= SCORE_MIN;
      second      <= SCORE_MIN;
      idx         <= '0;
      g           <= '0;
      predict_r   <= '0;
      max_score_r <= '0;
      margin_r    <= '0;
    end else if (accept) begin
      frame  <= FRAME_W'(bus.layer_out);
      best   <= SCORE_MIN;
      second <= SCORE_MIN;
      idx    <= '0;
      g      <= '0;
    end else if (state == SCAN) begin
      best   <= best_c[LANES];
      second <= second_c[LANES];
      idx    <= idx_c[LANES];
      g      <= g + 1'b1;
      if (last_group) begin
        predict_r   <= idx_c[LANES];
        max_score_r <= best_c[LANES];
        margin_r    <= margin_nxt;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.predict   = predict_r;
  assign bus.max_score = max_score_r;
  assign bus.margin    = margin_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_tcb_argmax_margin.sv
// Directed bench for tcb_argmax_margin: a 2-lane and a 3-lane instance over 10 classes of 40-bit scores.
module tb_tcb_argmax_margin;
  import tcb_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  state_t state0, state1;

  tcb_argmax_margin_if #(.N_CLASS(10), .SCORE_W(40), .IDX_W(32)) bus0 ();
  tcb_argmax_margin_if #(.N_CLASS(10), .SCORE_W(40), .IDX_W(32)) bus1 ();

  tcb_argmax_margin #(.N_CLASS(10), .SCORE_W(40), .LANES(2), .IDX_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(state0)
  );

  tcb_argmax_margin #(.N_CLASS(10), .SCORE_W(40), .LANES(3), .IDX_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(state1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  function automatic logic [399:0] pack10(input int v[10]);
    logic [399:0]       r;
    logic signed [39:0] t;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      t = v[i];
      r[i*40 +: 40] = t;
    end
    return r;
  endfunction

  task automatic wait_result0(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus0.out_valid !== 1'b1 && lat < 30);
  endtask

  task automatic handoff0();
    @(negedge clk);
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
  endtask

  task automatic run0(input logic [399:0] f, output int lat,
                      output logic [31:0] p, output logic [39:0] mx, output logic [40:0] mg);
    @(negedge clk);
    bus0.layer_out = f;
    bus0.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid  = 1'b0;
    bus0.layer_out = ~f;
    wait_result0(lat);
    p  = bus0.predict;
    mx = bus0.max_score;
    mg = bus0.margin;
    handoff0();
  endtask

  task automatic run1(input logic [399:0] f, output int lat,
                      output logic [31:0] p, output logic [39:0] mx, output logic [40:0] mg);
    @(negedge clk);
    bus1.layer_out = f;
    bus1.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid  = 1'b0;
    bus1.layer_out = ~f;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus1.out_valid !== 1'b1 && lat < 30);
    p  = bus1.predict;
    mx = bus1.max_score;
    mg = bus1.margin;
    @(negedge clk);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    #7;
    checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus0.in_ready); end
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus0.out_valid); end
    checks++; if (bus0.predict !== 32'd0) begin errors++; $display("FAIL reset_predict got=%0d exp=0", bus0.predict); end
    checks++; if (bus0.max_score !== 40'd0) begin errors++; $display("FAIL reset_max_score got=%h exp=0", bus0.max_score); end
    checks++; if (bus0.margin !== 41'd0) begin errors++; $display("FAIL reset_margin got=%h exp=0", bus0.margin); end
    checks++; if (state0 !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state0, IDLE); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ramp();
    int v[10]; int lat; logic [31:0] p; logic [39:0] mx; logic [40:0] mg;
    for (int i = 0; i < 10; i++) v[i] = 3 * i;
    run0(pack10(v), lat, p, mx, mg);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ramp_latency got=%0d exp=5", lat); end
    checks++; if (p !== 32'd9) begin errors++; $display("FAIL ramp_predict got=%0d exp=9", p); end
    checks++; if (mx !== 40'd27) begin errors++; $display("FAIL ramp_max got=%0d exp=27", mx); end
    checks++; if (mg !== 41'd3) begin errors++; $display("FAIL ramp_margin got=%0d exp=3", mg); end
    checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL ramp_in_ready_after got=%b exp=1", bus0.in_ready); end
    checks++; if (bus0.out_valid !== 1'b0 || bus0.predict !== 32'd9) begin
      errors++; $display("FAIL ramp_hold_after got_valid=%b got_predict=%0d exp_valid=0 exp_predict=9", bus0.out_valid, bus0.predict);
    end
  endtask

  task automatic test_peak();
    int v[10]; int lat; logic [31:0] p; logic [39:0] mx; logic [40:0] mg;
    logic signed [39:0] emx;
    for (int i = 0; i < 10; i++) v[i] = -100;
    v[4] = -5; v[7] = -6;
    emx = -5;
    run0(pack10(v), lat, p, mx, mg);
    checks++; if (p !== 32'd4) begin errors++; $display("FAIL peak_predict got=%0d exp=4", p); end
    checks++; if (mx !== emx) begin errors++; $display("FAIL peak_max got=%h exp=%h", mx, emx); end
    checks++; if (mg !== 41'd1) begin errors++; $display("FAIL peak_margin got=%0d exp=1", mg); end
  endtask

  task automatic test_tie();
    int v[10]; int lat; logic [31:0] p; logic [39:0] mx; logic [40:0] mg;
    for (int i = 0; i < 10; i++) v[i] = 0;
    v[2] = 500; v[8] = 500;
    run0(pack10(v), lat, p, mx, mg);
    checks++; if (p !== 32'd2) begin errors++; $display("FAIL tie_predict got=%0d exp=2", p); end
    checks++; if (mx !== 40'd500) begin errors++; $display("FAIL tie_max got=%0d exp=500", mx); end
    checks++; if (mg !== 41'd0) begin errors++; $display("FAIL tie_margin got=%0d exp=0", mg); end
  endtask

  task automatic test_all_min();
    logic [399:0] f; int lat; logic [31:0] p; logic [39:0] mx; logic [40:0] mg;
    for (int i = 0; i < 10; i++) f[i*40 +: 40] = {1'b1, 39'd0};
    run0(f, lat, p, mx, mg);
    checks++; if (p !== 32'd0) begin errors++; $display("FAIL allmin_predict got=%0d exp=0", p); end
    checks++; if (mx !== {1'b1, 39'd0}) begin errors++; $display("FAIL allmin_max got=%h exp=8000000000", mx); end
    checks++; if (mg !== 41'd0) begin errors++; $display("FAIL allmin_margin got=%0d exp=0", mg); end
  endtask

  task automatic test_backpressure();
    int va[10]; int vb[10]; int lat;
    logic signed [39:0] emx;
    for (int i = 0; i < 10; i++) begin va[i] = 3 * i; vb[i] = -100; end
    vb[4] = -5; vb[7] = -6;
    emx = -5;
    @(negedge clk);
    bus0.layer_out = pack10(va);
    bus0.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus0.layer_out = pack10(vb);  // second frame offered while the first is still in flight
    wait_result0(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL bp_latency got=%0d exp=5", lat); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_flags cyc=%0d got_valid=%b got_ready=%b exp_valid=1 exp_ready=0", c, bus0.out_valid, bus0.in_ready);
      end
      checks++; if (bus0.predict !== 32'd9 || bus0.max_score !== 40'd27 || bus0.margin !== 41'd3) begin
        errors++; $display("FAIL bp_hold_data cyc=%0d got=%0d/%0d/%0d exp=9/27/3", c, bus0.predict, bus0.max_score, bus0.margin);
      end
    end
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    checks++; if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got_ready=%b got_valid=%b exp_ready=1 exp_valid=0", bus0.in_ready, bus0.out_valid);
    end
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    checks++; if (state0 !== SCAN) begin errors++; $display("FAIL bp_second_accept got_state=%0d exp=%0d", state0, SCAN); end
    wait_result0(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL bp_second_latency got=%0d exp=5", lat); end
    checks++; if (bus0.predict !== 32'd4 || bus0.max_score !== emx || bus0.margin !== 41'd1) begin
      errors++; $display("FAIL bp_second_result got=%0d/%h/%0d exp=4/%h/1", bus0.predict, bus0.max_score, bus0.margin, emx);
    end
    handoff0();
  endtask

  task automatic test_reset_mid_scan();
    int v[10]; int lat; logic [31:0] p; logic [39:0] mx; logic [40:0] mg;
    int seen;
    for (int i = 0; i < 10; i++) v[i] = 3 * i;
    @(negedge clk);
    bus0.layer_out = pack10(v);
    bus0.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;  // group counter now at 3
    #1;
    checks++; if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_immediate got_ready=%b got_valid=%b exp_ready=1 exp_valid=0", bus0.in_ready, bus0.out_valid);
    end
    checks++; if (state0 !== IDLE) begin errors++; $display("FAIL midrst_state got=%0d exp=%0d", state0, IDLE); end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus0.out_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_result got=%0d exp=0", seen); end
    for (int i = 0; i < 10; i++) v[i] = -i;
    run0(pack10(v), lat, p, mx, mg);
    checks++; if (p !== 32'd0) begin errors++; $display("FAIL midrst_next_predict got=%0d exp=0", p); end
    checks++; if (mx !== 40'd0) begin errors++; $display("FAIL midrst_next_max got=%0d exp=0", mx); end
    checks++; if (mg !== 41'd1) begin errors++; $display("FAIL midrst_next_margin got=%0d exp=1", mg); end
  endtask

  task automatic test_lanes3();
    int v[10]; int lat; logic [31:0] p; logic [39:0] mx; logic [40:0] mg;
    logic signed [39:0] emx;
    for (int i = 0; i < 10; i++) v[i] = i;
    v[9] = 50;
    run1(pack10(v), lat, p, mx, mg);
    checks++; if (lat !== 4) begin errors++; $display("FAIL l3_latency got=%0d exp=4", lat); end
    checks++; if (p !== 32'd9) begin errors++; $display("FAIL l3_predict got=%0d exp=9", p); end
    checks++; if (mx !== 40'd50) begin errors++; $display("FAIL l3_max got=%0d exp=50", mx); end
    checks++; if (mg !== 41'd42) begin errors++; $display("FAIL l3_margin got=%0d exp=42", mg); end
    // All negative: the zero padding in the last group must not win.
    for (int i = 0; i < 10; i++) v[i] = -50;
    v[9] = -3; v[0] = -7;
    emx = -3;
    run1(pack10(v), lat, p, mx, mg);
    checks++; if (p !== 32'd9) begin errors++; $display("FAIL l3_neg_predict got=%0d exp=9", p); end
    checks++; if (mx !== emx) begin errors++; $display("FAIL l3_neg_max got=%h exp=%h", mx, emx); end
    checks++; if (mg !== 41'd4) begin errors++; $display("FAIL l3_neg_margin got=%0d exp=4", mg); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    bus0.layer_out = '0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    bus1.layer_out = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    test_reset();
    test_ramp();
    test_peak();
    test_tie();
    test_all_min();
    test_backpressure();
    test_reset_mid_scan();
    test_lanes3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tcb_argmax_margin.md
# tcb_argmax_margin

Parametrised classifier back-end for the TCB network pipeline. It replaces the fixed 10-class single-shot comparator at the end of a TCB top level. It accepts one frame of N_CLASS signed output-layer scores through a valid/ready handshake and scans them LANES classes per cycle. It returns the winning class index, the winning score and the confidence margin (best minus second-best), held under output backpressure.

## Interface
Parameters:
- N_CLASS, 10, number of classes; must be at least 2.
- SCORE_W, 40, width of one signed score.
- LANES, 2, classes compared per cycle; range 1..N_CLASS.
- IDX_W, 32, width of the predict output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- layer_out  in  N_CLASS*SCORE_W  scores; class i occupies bits [i*SCORE_W +: SCORE_W], two's complement.
- in_valid  in  1  frame present on layer_out.
- in_ready  out  1  block can accept a frame.
- predict  out  IDX_W  winning class index, zero-extended.
- max_score  out  SCORE_W  winning score.
- margin  out  SCORE_W+1  max_score minus second-best score; unsigned and never negative.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.

## Operation
- States:
  - IDLE: in_ready=1.
  - SCAN: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE→SCAN on in_valid&&in_ready. On that transition:
  - layer_out is captured into an internal frame register, so the source may change afterwards.
  - best and second are set to -2^(SCORE_W-1); best index is set to 0; group counter g is set to 0.
- SCAN processes lanes L=0..LANES-1 each cycle, class c=g*LANES+L, in ascending c:
  - lanes with c>=N_CLASS are ignored;
  - if score>best: second=best, best=score, idx=c;
  - else if score>second: second=score.
  - Comparisons are signed and strictly greater, so on a tie the lowest index wins and the tied score becomes second (margin 0).
- g increments each cycle. After group S-1, with S=ceil(N_CLASS/LANES), the block goes to DONE. On that same edge, predict, max_score and margin=best-second are registered; margin is computed at SCORE_W+1 bits.
- DONE→IDLE on out_ready. After handoff the outputs keep their last values with out_valid=0.
- A frame is never accepted while in SCAN or DONE. There is no overlap between frames.
- All scores equal to -2^(SCORE_W-1): predict=0, margin=0.

## Timing
- Reset values:
  - state=IDLE;
  - in_ready=1;
  - out_valid=0;
  - predict, max_score and margin all 0.
- Reset asserted in any state (including mid-SCAN) clears immediately. The partial frame is dropped and no out_valid is produced for it.
- out_valid rises exactly S rising edges after the accepting edge. With N_CLASS=10, LANES=2: 5 edges.
- in_ready returns to 1 the cycle after the out_valid&&out_ready edge.
- Minimum frame period: S+2 cycles with out_ready held high.
- While out_valid=1 and out_ready=0, predict, max_score and margin are stable.

## Structure
- Package tcb_pkg holds:
  - the state enum (IDLE/SCAN/DONE);
  - a ceil-divide function used for S and the g counter width ($clog2(S)+1);
  - the default SCORE_W/IDX_W constants shared with the layer modules.
- Sub-module tcb_top2_update is one combinational lane cell:
  - inputs: score, class index, best, second, idx, lane enable;
  - outputs: updated best, second, idx.
  - It is chained LANES times in index order.
- The top file holds the FSM, frame register, group counter and output registers.

## Test plan
- N_CLASS=10, LANES=2, score[i]=3*i -> out_valid 5 edges after accept, predict=9, max_score=27, margin=3.
- All scores -100 except class4=-5 and class7=-6 -> predict=4, max_score=-5, margin=1.
- Class2=class8=500, others 0 -> predict=2, max_score=500, margin=0.
- out_ready held 0 for 10 cycles in DONE, second frame offered on in_valid -> outputs stable, in_ready=0, second frame not accepted. Raising out_ready gives in_ready=1 on the next cycle, and the second frame then yields its own result.
- rst pulsed low during SCAN group 3 -> out_valid stays 0, in_ready=1 immediately. The next frame (score[i]=-i) gives predict=0, margin=1.
- LANES=3, N_CLASS=10 (S=4), maximum at class 9 in the partially filled last group -> predict=9, out_valid after 4 edges, padded lanes ignored.
